// File: rtl/alu_phase_seq_if.sv
// Request/enable bundle between the ALU phase sequencer and its datapath.
interface alu_phase_seq_if #(
  parameter int CNT_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_ra;
  logic [4:0]       req_rb;
  logic [4:0]       req_rw;
  logic [3:0]       req_op;
  logic             req_we;
  logic             step_mode;
  logic             step;
  logic [4:0]       R_Addr_A;
  logic [4:0]       R_Addr_B;
  logic [4:0]       W_Addr;
  logic [3:0]       ALU_OP;
  logic             Reg_Write;
  logic             rr_en;
  logic             f_en;
  logic             wb_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] op_count;

  modport master (
    output req_valid, req_ra, req_rb, req_rw, req_op, req_we, step_mode, step,
    input  req_ready, R_Addr_A, R_Addr_B, W_Addr, ALU_OP, Reg_Write,
           rr_en, f_en, wb_en, busy, done, op_count
  );

  modport slave (
    input  req_valid, req_ra, req_rb, req_rw, req_op, req_we, step_mode, step,
    output req_ready, R_Addr_A, R_Addr_B, W_Addr, ALU_OP, Reg_Write,
           rr_en, f_en, wb_en, busy, done, op_count
  );
endinterface

// File: rtl/alu_phase_seq.sv
// Sequencer for register read -> operand latch -> ALU/flag latch -> write-back,
// producing one-cycle phase enables instead of separate phase clocks.
//
//   state  | meaning
//   IDLE   | ready for a request; latched fields hold the last operation
//   READ   | register file addressed; rr_en on go
//   EXEC   | ALU settling for EXEC_WAIT cycles, then f_en on go
//   WB     | wb_en (if Reg_Write) on go
//   DONE   | done pulse, op_count increment, back to IDLE
module alu_phase_seq #(
  parameter int EXEC_WAIT = 0,
  parameter int CNT_W     = 16
) (
  input  logic           clk,
  input  logic           rst,
  alu_phase_seq_if.slave io_bus
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WB, S_DONE} state_t;

  localparam logic [3:0] LP_WAIT = 4'(EXEC_WAIT);

  state_t           r_state;
  state_t           w_next;
  logic             r_step_q;
  logic [3:0]       r_wait;
  logic [4:0]       r_ra;
  logic [4:0]       r_rb;
  logic [4:0]       r_rw;
  logic [3:0]       r_op;
  logic             r_reg_write;
  logic [CNT_W-1:0] r_op_count;

  logic w_step_rise;
  logic w_go;
  logic w_wait_zero;
  logic w_accept;
  logic w_rr_en;
  logic w_f_en;
  logic w_wb_en;

  // A step rise is only consumed by the state it arrives in; nothing stores it.
  assign w_step_rise = io_bus.step & ~r_step_q;
  assign w_go        = ~io_bus.step_mode | w_step_rise;
  assign w_wait_zero = (r_wait == 4'd0);
  assign w_accept    = (r_state == S_IDLE) & io_bus.req_valid;

  // Next-state and enable decode from the registered state and go.
  always_comb begin
    w_next  = r_state;
    w_rr_en = 1'b0;
    w_f_en  = 1'b0;
    w_wb_en = 1'b0;
    unique case (r_state)
      S_IDLE: if (io_bus.req_valid) w_next = S_READ;
      S_READ: if (w_go) begin
        w_rr_en = 1'b1;
        w_next  = S_EXEC;
      end
      S_EXEC: if (w_wait_zero && w_go) begin
        w_f_en = 1'b1;
        w_next = S_WB;
      end
      S_WB: if (w_go) begin
        w_wb_en = r_reg_write;
        w_next  = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Step edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_step_q <= 1'b0;
    else     r_step_q <= io_bus.step;
  end

  // Request fields are captured on acceptance only and held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ra        <= '0;
      r_rb        <= '0;
      r_rw        <= '0;
      r_op        <= '0;
      r_reg_write <= 1'b0;
    end else if (w_accept) begin
      r_ra        <= io_bus.req_ra;
      r_rb        <= io_bus.req_rb;
      r_rw        <= io_bus.req_rw;
      r_op        <= io_bus.req_op;
      r_reg_write <= io_bus.req_we & (io_bus.req_rw != 5'd0);
    end
  end

  // ALU settle counter: loaded leaving READ, counts down in EXEC regardless of go.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait <= '0;
    end else if (r_state == S_READ && w_go) begin
      r_wait <= LP_WAIT;
    end else if (r_state == S_EXEC && !w_wait_zero) begin
      r_wait <= r_wait - 4'd1;
    end
  end

  // Completed-operation counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_op_count <= '0;
    else if (r_state == S_DONE) r_op_count <= r_op_count + 1'b1;
  end

  assign io_bus.req_ready = (r_state == S_IDLE) & ~rst;
  assign io_bus.busy      = (r_state != S_IDLE);
  assign io_bus.done      = (r_state == S_DONE);
  assign io_bus.rr_en     = w_rr_en;
  assign io_bus.f_en      = w_f_en;
  assign io_bus.wb_en     = w_wb_en;
  assign io_bus.R_Addr_A  = r_ra;
  assign io_bus.R_Addr_B  = r_rb;
  assign io_bus.W_Addr    = r_rw;
  assign io_bus.ALU_OP    = r_op;
  assign io_bus.Reg_Write = r_reg_write;
  assign io_bus.op_count  = r_op_count;

endmodule

// File: tb/tb_alu_phase_seq.sv
// Scoreboard bench for alu_phase_seq: one instance with EXEC_WAIT=0 and one
// with EXEC_WAIT=3, selected by sel; a negedge monitor times each operation.
module tb_alu_phase_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_phase_seq_if #(.CNT_W(16)) if0 ();
  alu_phase_seq_if #(.CNT_W(16)) if3 ();

  alu_phase_seq #(.EXEC_WAIT(0), .CNT_W(16)) u_dut0 (.clk(clk), .rst(rst), .io_bus(if0.slave));
  alu_phase_seq #(.EXEC_WAIT(3), .CNT_W(16)) u_dut3 (.clk(clk), .rst(rst), .io_bus(if3.slave));

  logic       sel = 1'b0;
  logic       req_valid = 1'b0;
  logic [4:0] ra = '0, rb = '0, rw = '0;
  logic [3:0] op = '0;
  logic       we = 1'b0, step_mode = 1'b0, step = 1'b0;

  assign if0.req_valid = req_valid & ~sel;
  assign if3.req_valid = req_valid & sel;
  assign if0.req_ra = ra;  assign if3.req_ra = ra;
  assign if0.req_rb = rb;  assign if3.req_rb = rb;
  assign if0.req_rw = rw;  assign if3.req_rw = rw;
  assign if0.req_op = op;  assign if3.req_op = op;
  assign if0.req_we = we;  assign if3.req_we = we;
  assign if0.step_mode = step_mode;  assign if3.step_mode = step_mode;
  assign if0.step = step;  assign if3.step = step;

  wire        m_rr    = sel ? if3.rr_en     : if0.rr_en;
  wire        m_f     = sel ? if3.f_en      : if0.f_en;
  wire        m_wb    = sel ? if3.wb_en     : if0.wb_en;
  wire        m_done  = sel ? if3.done      : if0.done;
  wire        m_busy  = sel ? if3.busy      : if0.busy;
  wire        m_ready = sel ? if3.req_ready : if0.req_ready;
  wire        m_valid = sel ? if3.req_valid : if0.req_valid;
  wire [4:0]  m_ra    = sel ? if3.R_Addr_A  : if0.R_Addr_A;
  wire [4:0]  m_rb    = sel ? if3.R_Addr_B  : if0.R_Addr_B;
  wire [4:0]  m_rw    = sel ? if3.W_Addr    : if0.W_Addr;
  wire [3:0]  m_op    = sel ? if3.ALU_OP    : if0.ALU_OP;
  wire        m_regw  = sel ? if3.Reg_Write : if0.Reg_Write;
  wire [15:0] m_cnt   = sel ? if3.op_count  : if0.op_count;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0]  ra, rb, rw;
    logic [3:0]  op;
    logic        regw;
    int          w;
    bit          timed;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mcnt [2];

  task automatic push_exp(input bit timed);
    exp_t e;
    e.ra = ra; e.rb = rb; e.rw = rw; e.op = op;
    e.regw  = we && (rw != 5'd0);
    e.w     = sel ? 3 : 0;
    e.timed = timed;
    mcnt[sel] = mcnt[sel] + 16'd1;
    e.cnt   = mcnt[sel];
    sb.push_back(e);
  endtask

  // Monitor: per-operation timing relative to the accept cycle.
  int   cyc = 0, n_acc = 0, n_done = 0, tot_rr = 0, tot_f = 0, tot_wb = 0;
  int   acc_c = 0, rr_c = 0, f_c = 0, wb_c = 0, n_rr = 0, n_f = 0, n_wb = 0;
  int   last_acc = 0, acc_gap = 0;
  bit   in_op = 0, overlap = 0, pend = 0;
  logic [15:0] pend_cnt = '0;
  exp_t me;

  always @(negedge clk) begin
    cyc++;
    tot_rr += int'(m_rr);
    tot_f  += int'(m_f);
    tot_wb += int'(m_wb);
    if (rst) begin
      in_op = 0;
      pend  = 0;
    end else begin
      if (pend) begin
        chk_eq("op_count", 32'(m_cnt), 32'(pend_cnt));
        pend = 0;
      end
      if (in_op) begin
        if (int'(m_rr) + int'(m_f) + int'(m_wb) > 1) overlap = 1;
        if (m_rr) begin n_rr++; rr_c = cyc; end
        if (m_f)  begin n_f++;  f_c  = cyc; end
        if (m_wb) begin n_wb++; wb_c = cyc; end
      end
      if (m_done) begin
        n_done++;
        if (!in_op) chk_eq("done_without_accept", 32'd1, 32'd0);
        else if (sb.size() == 0) chk_eq("scoreboard_empty", 32'd1, 32'd0);
        else begin
          me = sb.pop_front();
          chk_eq("R_Addr_A", 32'(m_ra), 32'(me.ra));
          chk_eq("R_Addr_B", 32'(m_rb), 32'(me.rb));
          chk_eq("W_Addr", 32'(m_rw), 32'(me.rw));
          chk_eq("ALU_OP", 32'(m_op), 32'(me.op));
          chk_eq("Reg_Write", 32'(m_regw), 32'(me.regw));
          chk_eq("rr_en_count", 32'(n_rr), 32'd1);
          chk_eq("f_en_count", 32'(n_f), 32'd1);
          chk_eq("wb_en_count", 32'(n_wb), me.regw ? 32'd1 : 32'd0);
          chk_eq("enable_overlap", 32'(overlap), 32'd0);
          if (me.timed) begin
            chk_eq("rr_en_cycle", 32'(rr_c - acc_c), 32'd1);
            chk_eq("f_en_cycle", 32'(f_c - acc_c), 32'(2 + me.w));
            if (me.regw) chk_eq("wb_en_cycle", 32'(wb_c - acc_c), 32'(3 + me.w));
            chk_eq("done_cycle", 32'(cyc - acc_c), 32'(4 + me.w));
          end else begin
            chk_eq("order_rr_f", 32'(f_c > rr_c), 32'd1);
            if (me.regw) chk_eq("order_f_wb", 32'(wb_c > f_c), 32'd1);
            chk_eq("order_done", 32'(cyc > f_c), 32'd1);
          end
          pend     = 1;
          pend_cnt = me.cnt;
        end
        in_op = 0;
      end
      if (m_ready && m_valid) begin
        in_op = 1; overlap = 0;
        n_rr = 0; n_f = 0; n_wb = 0;
        acc_gap  = cyc - last_acc;
        last_acc = cyc;
        acc_c    = cyc;
        n_acc++;
      end
    end
  end

  task automatic set_req(input logic [4:0] a, input logic [4:0] b, input logic [4:0] w,
                         input logic [3:0] o, input logic e);
    ra = a; rb = b; rw = w; op = o; we = e;
  endtask

  task automatic wait_acc(input int target);
    for (int i = 0; i < 30 && n_acc < target; i++) @(posedge clk);
    chk_eq("accept_seen", 32'(n_acc >= target), 32'd1);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 80 && n_done < target; i++) @(posedge clk);
    chk_eq("done_seen", 32'(n_done >= target), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_op();
    int t;
    push_exp(1'b1);
    t = n_done + 1;
    req_valid = 1'b1;
    wait_acc(n_acc + 1);
    #1 req_valid = 1'b0;
    wait_done(t);
  endtask

  task automatic step_pulse(input logic e_rr, input logic e_f, input logic e_wb);
    @(posedge clk);
    #1 step = 1'b1;
    #2;
    chk_eq("step_rr_en", 32'(m_rr), 32'(e_rr));
    chk_eq("step_f_en", 32'(m_f), 32'(e_f));
    chk_eq("step_wb_en", 32'(m_wb), 32'(e_wb));
    @(posedge clk);
    #1 step = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, s_rr, s_f, s_wb;
    mcnt[0] = '0;
    mcnt[1] = '0;

    // Reset behaviour
    repeat (3) @(posedge clk);
    #3;
    chk_eq("rst_enables", 32'({if0.rr_en, if0.f_en, if0.wb_en, if0.done, if0.busy}), 32'd0);
    chk_eq("rst_ready", 32'(if0.req_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #2;
    chk_eq("post_rst_ready", 32'(if0.req_ready), 32'd1);
    chk_eq("post_rst_waddr", 32'(if0.W_Addr), 32'd0);
    chk_eq("post_rst_count", 32'(if0.op_count), 32'd0);
    repeat (2) @(posedge clk);
    chk_eq("no_enables_around_reset", 32'(tot_rr + tot_f + tot_wb), 32'd0);
    #1;

    // Basic free-running operation, fields held after done
    set_req(5'd1, 5'd2, 5'd3, 4'h2, 1'b1);
    run_op();
    set_req(5'd17, 5'd18, 5'd19, 4'hF, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    chk_eq("held_W_Addr", 32'(if0.W_Addr), 32'd3);
    chk_eq("held_Reg_Write", 32'(if0.Reg_Write), 32'd1);
    chk_eq("held_R_Addr_A", 32'(if0.R_Addr_A), 32'd1);
    #1;

    // x0 destination and we=0
    set_req(5'd1, 5'd2, 5'd0, 4'h2, 1'b1);
    run_op();
    set_req(5'd7, 5'd9, 5'd5, 4'hA, 1'b0);
    run_op();

    // EXEC_WAIT=3 free-running, step toggling has no effect
    sel = 1'b1;
    set_req(5'd4, 5'd5, 5'd6, 4'h3, 1'b1);
    fork
      run_op();
      begin
        repeat (12) begin
          @(posedge clk);
          #1 step = ~step;
        end
        step = 1'b0;
      end
    join

    // EXEC_WAIT=3 in step mode: rises during the wait are discarded
    step_mode = 1'b1;
    set_req(5'd21, 5'd22, 5'd23, 4'h7, 1'b1);
    push_exp(1'b0);
    t = n_done + 1;
    req_valid = 1'b1;
    wait_acc(n_acc + 1);
    #1 req_valid = 1'b0;
    step_pulse(1'b1, 1'b0, 1'b0);
    step_pulse(1'b0, 1'b0, 1'b0);
    s_f = tot_f;
    repeat (4) @(posedge clk);
    #3;
    chk_eq("wait_rise_discarded", 32'(tot_f), 32'(s_f));
    step_pulse(1'b0, 1'b1, 1'b0);
    step_pulse(1'b0, 1'b0, 1'b1);
    #2 chk_eq("step_done_w3", 32'(m_done), 32'd1);
    step_mode = 1'b0;
    wait_done(t);

    // Step mode on W=0: stall without steps, then one phase per rise
    sel = 1'b0;
    step_mode = 1'b1;
    set_req(5'd11, 5'd12, 5'd8, 4'h9, 1'b1);
    push_exp(1'b0);
    t = n_done + 1;
    req_valid = 1'b1;
    wait_acc(n_acc + 1);
    #1 req_valid = 1'b0;
    s_rr = tot_rr; s_f = tot_f; s_wb = tot_wb;
    repeat (20) @(posedge clk);
    #3;
    chk_eq("stall_no_enables", 32'(tot_rr + tot_f + tot_wb), 32'(s_rr + s_f + s_wb));
    chk_eq("stall_busy", 32'(m_busy), 32'd1);
    step_pulse(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1 step = 1'b1;
    #2 chk_eq("hold_first_f_en", 32'(m_f), 32'd1);
    repeat (3) begin
      @(posedge clk);
      #3;
      chk_eq("hold_no_advance", 32'({m_wb, m_done}), 32'd0);
      chk_eq("hold_busy", 32'(m_busy), 32'd1);
    end
    step = 1'b0;
    step_pulse(1'b0, 1'b0, 1'b1);
    #2 chk_eq("step_done_auto", 32'(m_done), 32'd1);
    step_mode = 1'b0;
    wait_done(t);

    // Reset during EXEC
    sel = 1'b1;
    set_req(5'd2, 5'd3, 5'd4, 4'h1, 1'b1);
    req_valid = 1'b1;
    wait_acc(n_acc + 1);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    s_rr = tot_rr; s_f = tot_f; s_wb = tot_wb;
    rst = 1'b1;
    #1;
    chk_eq("midrst_busy", 32'(m_busy), 32'd0);
    chk_eq("midrst_enables", 32'({m_rr, m_f, m_wb, m_done}), 32'd0);
    chk_eq("midrst_fields", 32'({m_ra, m_rb, m_rw, m_op, m_regw}), 32'd0);
    chk_eq("midrst_count", 32'(m_cnt), 32'd0);
    mcnt[0] = '0;
    mcnt[1] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #2 chk_eq("midrst_ready", 32'(m_ready), 32'd1);
    repeat (10) @(posedge clk);
    chk_eq("aborted_no_enables", 32'(tot_rr + tot_f + tot_wb), 32'(s_rr + s_f + s_wb));
    #1;

    // op_count wrap
    sel = 1'b0;
    force u_dut0.r_op_count = 16'hFFFF;
    #1 release u_dut0.r_op_count;
    mcnt[0] = 16'hFFFF;
    #1 chk_eq("preload_count", 32'(if0.op_count), 32'hFFFF);
    set_req(5'd6, 5'd7, 5'd9, 4'h4, 1'b1);
    run_op();

    // Back-to-back with req_valid held high
    set_req(5'd10, 5'd11, 5'd12, 4'h5, 1'b1);
    push_exp(1'b1);
    t = n_done + 2;
    req_valid = 1'b1;
    wait_acc(n_acc + 1);
    #1 set_req(5'd13, 5'd14, 5'd15, 4'h6, 1'b0);
    push_exp(1'b1);
    wait_acc(n_acc + 1);
    #1 req_valid = 1'b0;
    chk_eq("back_to_back_gap", 32'(acc_gap), 32'd5);
    wait_done(t);

    repeat (3) @(posedge clk);
    chk_eq("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
